// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types, default thresholds and pointer helper for sync_fifo_flags
package fifo_pkg;

    localparam int AEMPTY_TH_DEF    = 2;
    localparam int AFULL_MARGIN_DEF = 2;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Advance a pointer, wrapping from depth-1 back to 0 (depth need not be a power of two)
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: accept logic plus read/write pointer and occupancy arithmetic
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic             rd,
    output logic             wr_acc,
    output logic             rd_acc,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] cnt
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accepts use pre-edge state; flush drops both requests so neither can raise an error
    always_comb begin
        rd_acc   = !flush && rd && (cnt_q != '0);
        wr_acc   = !flush && wr && ((cnt_q != CNT_W'(DEPTH)) || rd_acc);
        wr_ptr_d = flush ? '0 : wr_acc ? PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH)) : wr_ptr_q;
        rd_ptr_d = flush ? '0 : rd_acc ? PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH)) : rd_ptr_q;
        cnt_d    = flush ? '0 :
                   (wr_acc && !rd_acc) ? cnt_q + CNT_W'(1) :
                   (rd_acc && !wr_acc) ? cnt_q - CNT_W'(1) : cnt_q;
    end

    // Pointer and count registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign cnt    = cnt_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised synchronous FIFO with threshold flags, sticky errors and flush
// Optional parity protection per entry is enabled by defining SYNC_FIFO_PARITY_EN.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 16,
    parameter  int AFULL_TH  = DEPTH - AFULL_MARGIN_DEF,
    parameter  int AEMPTY_TH = AEMPTY_TH_DEF,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int PTR_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow,
`ifdef SYNC_FIFO_PARITY_EN
    input  logic             inj_par_err,
    output logic             parity_err,
`endif
    input  logic             clr_err
);

`ifdef SYNC_FIFO_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif

    logic             wr_acc, rd_acc;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    mem_q [DEPTH];
    logic [MW-1:0]    wr_word, rd_word;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    fifo_status_t     st;

    fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr     (wr),
        .rd     (rd),
        .wr_acc (wr_acc),
        .rd_acc (rd_acc),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .cnt    (cnt)
    );

`ifdef SYNC_FIFO_PARITY_EN
    assign wr_word = {(^data_in) ^ inj_par_err, data_in};
`else
    assign wr_word = data_in;
`endif
    assign rd_word = mem_q[rd_ptr];

    // Storage is not reset; only accepted writes outside reset land in memory
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem_q[wr_ptr] <= wr_word;
    end

    // Next-state for the output register and sticky errors; a new error beats clr_err
    always_comb begin
        data_out_d = rd_acc ? rd_word[WIDTH-1:0] : data_out_q;
        rd_valid_d = rd_acc;
        ovf_d      = (wr && !flush && !wr_acc) ? 1'b1 : clr_err ? 1'b0 : ovf_q;
        udf_d      = (rd && !flush && !rd_acc) ? 1'b1 : clr_err ? 1'b0 : udf_q;
    end

    // Output and error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

`ifdef SYNC_FIFO_PARITY_EN
    logic par_err_q, par_err_d;

    // Parity check on the popped word, pulsed alongside rd_valid
    always_comb begin
        par_err_d = rd_acc && (^rd_word);
    end

    // Parity error pulse register
    always_ff @(posedge clk) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign parity_err = par_err_q;
`endif

    // Status flags follow the count combinationally
    always_comb begin
        st.empty        = (cnt == '0);
        st.full         = (cnt == CNT_W'(DEPTH));
        st.almost_empty = (int'(cnt) <= AEMPTY_TH);
        st.almost_full  = (int'(cnt) >= AFULL_TH);
        st.overflow     = ovf_q;
        st.underflow    = udf_q;
    end

    assign data_out     = data_out_q;
    assign rd_valid     = rd_valid_q;
    assign fifo_cnt     = cnt;
    assign empty        = st.empty;
    assign full         = st.full;
    assign almost_empty = st.almost_empty;
    assign almost_full  = st.almost_full;
    assign overflow     = st.overflow;
    assign underflow    = st.underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed table plus corner-case sequences for DEPTH=16 and DEPTH=5 FIFOs
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, flush = 1'b0, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] a_dout, b_dout;
    logic [4:0] a_cnt;
    logic [2:0] b_cnt;
    logic a_rv, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
    logic b_rv, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;

    int errors = 0;
    int checks = 0;

`ifdef SYNC_FIFO_PARITY_EN
    logic inj_par_err = 1'b0;
    logic a_par, b_par;
`endif

    sync_fifo_flags #(.WIDTH(8), .DEPTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(a_dout), .rd_valid(a_rv), .fifo_cnt(a_cnt), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af), .overflow(a_ovf), .underflow(a_udf),
`ifdef SYNC_FIFO_PARITY_EN
        .inj_par_err(inj_par_err), .parity_err(a_par),
`endif
        .clr_err(clr_err)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .data_in(data_in), .rd(rd),
        .data_out(b_dout), .rd_valid(b_rv), .fifo_cnt(b_cnt), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af), .overflow(b_ovf), .underflow(b_udf),
`ifdef SYNC_FIFO_PARITY_EN
        .inj_par_err(inj_par_err), .parity_err(b_par),
`endif
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, flush, wr, rd, clr;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       rv, ovf, udf;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic r, f, w, rr, c, input logic [7:0] d,
                                input int n, input logic [7:0] o, input logic v, ov, ud);
        vec_t x;
        x.rst_n = r; x.flush = f; x.wr = w; x.rd = rr; x.clr = c; x.din = d;
        x.cnt = n; x.dout = o; x.rv = v; x.ovf = ov; x.udf = ud;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set(input logic r, f, w, rr, c, input logic [7:0] d);
        rst_n = r; flush = f; wr = w; rd = rr; clr_err = c; data_in = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flags16(input string t, input int c);
        chk({t, ".cnt"}, int'(a_cnt), c);
        chk({t, ".empty"}, int'(a_empty), int'(c == 0));
        chk({t, ".full"}, int'(a_full), int'(c == 16));
        chk({t, ".aempty"}, int'(a_ae), int'(c <= 2));
        chk({t, ".afull"}, int'(a_af), int'(c >= 14));
    endtask

    task automatic flags5(input string t, input int c);
        chk({t, ".b_cnt"}, int'(b_cnt), c);
        chk({t, ".b_empty"}, int'(b_empty), int'(c == 0));
        chk({t, ".b_full"}, int'(b_full), int'(c == 5));
        chk({t, ".b_afull"}, int'(b_af), int'(c >= 3));
    endtask

    initial begin
        tbl[0]  = mk(0,0,1,0,0,8'h55, 0,8'h00,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,8'h00, 0,8'h00,0,0,0);
        tbl[2]  = mk(1,0,0,0,0,8'h00, 0,8'h00,0,0,0);
        tbl[3]  = mk(1,0,0,1,0,8'h00, 0,8'h00,0,0,1);
        tbl[4]  = mk(1,0,1,1,0,8'h3C, 1,8'h00,0,0,1);
        tbl[5]  = mk(1,0,0,1,0,8'h00, 0,8'h3C,1,0,1);
        tbl[6]  = mk(1,0,0,0,1,8'h00, 0,8'h3C,0,0,0);
        tbl[7]  = mk(1,0,1,0,0,8'hA1, 1,8'h3C,0,0,0);
        tbl[8]  = mk(1,0,1,0,0,8'hA2, 2,8'h3C,0,0,0);
        tbl[9]  = mk(1,0,1,1,0,8'hA3, 2,8'hA1,1,0,0);
        tbl[10] = mk(1,0,0,1,0,8'h00, 1,8'hA2,1,0,0);
        tbl[11] = mk(1,0,0,1,1,8'h00, 0,8'hA3,1,0,0);
        tbl[12] = mk(1,0,0,1,1,8'h00, 0,8'hA3,0,0,1);
        tbl[13] = mk(1,1,1,1,0,8'h77, 0,8'hA3,0,0,1);
        tbl[14] = mk(1,0,0,0,1,8'h00, 0,8'hA3,0,0,0);
        tbl[15] = mk(1,0,1,0,0,8'h11, 1,8'hA3,0,0,0);
        tbl[16] = mk(1,1,0,1,0,8'h00, 0,8'hA3,0,0,0);
        tbl[17] = mk(1,0,0,1,0,8'h00, 0,8'hA3,0,0,1);
        tbl[18] = mk(0,0,0,0,0,8'h00, 0,8'h00,0,0,0);

        for (int i = 0; i < 19; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            set(tbl[i].rst_n, tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            tick();
            flags16(t, tbl[i].cnt);
            chk({t, ".dout"}, int'(a_dout), int'(tbl[i].dout));
            chk({t, ".rv"}, int'(a_rv), int'(tbl[i].rv));
            chk({t, ".ovf"}, int'(a_ovf), int'(tbl[i].ovf));
            chk({t, ".udf"}, int'(a_udf), int'(tbl[i].udf));
        end

        // Fill 16 entries; the 5-deep copy saturates and overflows along the way
        for (int i = 1; i <= 16; i++) begin
            set(1,0,1,0,0,8'(i));
            tick();
            flags16($sformatf("fill%0d", i), i);
            chk($sformatf("fill%0d.b_cnt", i), int'(b_cnt), (i > 5) ? 5 : i);
            chk($sformatf("fill%0d.b_ovf", i), int'(b_ovf), int'(i > 5));
        end
        set(1,0,1,0,0,8'hEE);
        tick();
        flags16("ovf", 16);
        chk("ovf.flag", int'(a_ovf), 1);
        set(1,0,0,0,1,8'h00);
        tick();
        chk("clr.ovf", int'(a_ovf), 0);
        chk("clr.b_ovf", int'(b_ovf), 0);
        set(1,0,1,1,0,8'hAA);
        tick();
        flags16("fullrw", 16);
        chk("fullrw.ovf", int'(a_ovf), 0);
        chk("fullrw.dout", int'(a_dout), 8'h01);
        chk("fullrw.rv", int'(a_rv), 1);
        for (int i = 0; i < 16; i++) begin
            set(1,0,0,1,0,8'h00);
            tick();
            flags16($sformatf("drain%0d", i), 15 - i);
            chk($sformatf("drain%0d.dout", i), int'(a_dout), (i < 15) ? i + 2 : 8'hAA);
            chk($sformatf("drain%0d.rv", i), int'(a_rv), 1);
        end
        set(1,0,0,0,0,8'h00);
        tick();
        chk("idle.rv", int'(a_rv), 0);
        chk("idle.dout", int'(a_dout), 8'hAA);
        set(1,0,0,1,0,8'h00);
        tick();
        chk("udf.flag", int'(a_udf), 1);
        chk("udf.rv", int'(a_rv), 0);
        chk("udf.dout", int'(a_dout), 8'hAA);
        set(1,0,0,0,1,8'h00);
        tick();
        chk("clr2.udf", int'(a_udf), 0);
        chk("clr2.ovf", int'(a_ovf), 0);

        // Pointer wrap on the non-power-of-two 5-deep FIFO
        set(0,0,0,0,0,8'h00);
        tick();
        flags5("w_rst", 0);
        for (int i = 0; i < 3; i++) begin
            set(1,0,1,0,0,8'(8'h10 + i));
            tick();
            flags5($sformatf("w_a%0d", i), i + 1);
        end
        for (int i = 0; i < 3; i++) begin
            set(1,0,0,1,0,8'h00);
            tick();
            chk($sformatf("w_b%0d.dout", i), int'(b_dout), 8'h10 + i);
            flags5($sformatf("w_b%0d", i), 2 - i);
        end
        for (int i = 0; i < 4; i++) begin
            set(1,0,1,0,0,8'(8'h20 + i));
            tick();
            flags5($sformatf("w_c%0d", i), i + 1);
        end
        for (int i = 0; i < 4; i++) begin
            set(1,0,0,1,0,8'h00);
            tick();
            chk($sformatf("w_d%0d.dout", i), int'(b_dout), 8'h20 + i);
            chk($sformatf("w_d%0d.rv", i), int'(b_rv), 1);
        end
        for (int i = 0; i < 6; i++) begin
            set(1,0,1,0,0,8'(8'h30 + i));
            tick();
            flags5($sformatf("w_e%0d", i), (i < 5) ? i + 1 : 5);
            chk($sformatf("w_e%0d.b_ovf", i), int'(b_ovf), int'(i == 5));
        end
        for (int i = 0; i < 5; i++) begin
            set(1,0,0,1,0,8'h00);
            tick();
            chk($sformatf("w_f%0d.dout", i), int'(b_dout), 8'h30 + i);
            flags5($sformatf("w_f%0d", i), 4 - i);
        end

        // Flush with a concurrent write, then a mid-stream reset
        set(0,0,0,0,0,8'h00);
        tick();
        for (int i = 0; i < 7; i++) begin
            set(1,0,1,0,0,8'(8'h61 + i));
            tick();
        end
        flags16("pre_flush", 7);
        set(1,1,1,0,0,8'h99);
        tick();
        flags16("flush", 0);
        chk("flush.ovf", int'(a_ovf), 0);
        chk("flush.rv", int'(a_rv), 0);
        set(1,0,0,1,0,8'h00);
        tick();
        chk("postflush.udf", int'(a_udf), 1);
        for (int i = 0; i < 3; i++) begin
            set(1,0,1,0,0,8'(8'h41 + i));
            tick();
        end
        flags16("refill", 3);
        set(0,0,0,0,0,8'h00);
        tick();
        flags16("midrst", 0);
        chk("midrst.udf", int'(a_udf), 0);
        chk("midrst.ovf", int'(a_ovf), 0);
        chk("midrst.dout", int'(a_dout), 0);
        set(1,0,1,0,0,8'h51);
        tick();
        flags16("newwr", 1);
        set(1,0,0,1,0,8'h00);
        tick();
        chk("newrd.dout", int'(a_dout), 8'h51);
        chk("newrd.rv", int'(a_rv), 1);
        flags16("newrd", 0);

        set(1,0,0,0,0,8'h00);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
